sdf_stage_ctrl: RTL and testbench

Sequencer for one radix-2 single-delay-feedback (SDF) NTT stage: input mux, delay FIFO, butterfly, output mux and twiddle multiplier.
- Counts accepted samples and decides each cycle whether the stage fills the delay line or runs butterflies.
- Drives the mux selects, FIFO push/pop and butterfly enable.
- Generates the twiddle ROM address for the Montgomery multiplier.
- One instance per pipeline stage; stages are chained by out_valid -> in_valid.

---
 rtl/sdf_stage_ctrl_if.sv | 27 ++
 rtl/sdf_stage_ctrl.sv | 80 ++++++++
 tb/tb_sdf_stage_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sdf_stage_ctrl_if.sv
// sdf_stage_ctrl_if: handshake and datapath-control bundle of one SDF NTT stage.
interface sdf_stage_ctrl_if #(
    parameter int TW_AW = 2
);
    logic             in_valid;
    logic             in_ready;
    logic             drain;
    logic             sel_in;
    logic             sel_out;
    logic             push;
    logic             pop;
    logic             bf_en;
    logic [TW_AW-1:0] tw_addr;
    logic             out_valid;
    logic             frame_done;
    logic             busy;

    modport master (
        output in_valid, drain,
        input  in_ready, sel_in, sel_out, push, pop, bf_en, tw_addr, out_valid, frame_done, busy
    );

    modport slave (
        input  in_valid, drain,
        output in_ready, sel_in, sel_out, push, pop, bf_en, tw_addr, out_valid, frame_done, busy
    );
endinterface

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: sequencer for one radix-2 SDF NTT stage (fill/butterfly/drain control, twiddle address).
// Define SDF_TW_BITREV_EN to emit bit-reversed twiddle addresses.
module sdf_stage_ctrl #(
    parameter int N     = 8,
    parameter int DELAY = 4,
    parameter int TW_AW = $clog2(N/2)
) (
    input logic             clk,
    input logic             rst,
    sdf_stage_ctrl_if.slave io
);
    localparam int CW      = $clog2(2*DELAY);
    localparam int FW      = $clog2(N);
    localparam int TW_STEP = N/(2*DELAY);

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t           r_state, w_state_nx;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic [FW-1:0]    r_fcnt, w_fcnt_nx;
    logic             r_primed, w_primed_nx;
    logic             w_run_adv, w_adv, w_phase, w_bf;
    logic [CW-1:0]    w_idx;
    logic [TW_AW-1:0] w_tw_nat, w_tw;

    assign w_run_adv = r_state == RUN && io.in_valid;
    assign w_adv     = w_run_adv || r_state == DRAIN;
    assign w_phase   = r_cnt[CW-1];
    assign w_bf      = w_run_adv && w_phase;
    assign w_idx     = r_cnt & CW'(DELAY-1);
    assign w_tw_nat  = TW_AW'(32'(w_idx) * 32'(TW_STEP));

`ifdef SDF_TW_BITREV_EN
    for (genvar i = 0; i < TW_AW; i++) begin : g_rev
        assign w_tw[i] = w_tw_nat[TW_AW-1-i];
    end
`else
    assign w_tw = w_tw_nat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_fcnt   <= '0;
            r_primed <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_fcnt   <= w_fcnt_nx;
            r_primed <= w_primed_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = w_adv ? r_cnt + 1'b1 : r_cnt;
        w_fcnt_nx   = w_run_adv ? r_fcnt + 1'b1 : r_fcnt;
        w_primed_nx = r_primed || (w_run_adv && r_cnt == CW'(2*DELAY-1));
        // drain is only honoured on a block boundary with a primed delay line and no incoming sample
        if (r_state == RUN && !io.in_valid && io.drain && r_primed && r_cnt == '0)
            w_state_nx = DRAIN;
        if (r_state == DRAIN && r_cnt == CW'(DELAY-1)) begin
            w_state_nx  = RUN;
            w_cnt_nx    = '0;
            w_primed_nx = 1'b0;
        end
    end

    assign io.in_ready   = r_state == RUN;
    assign io.busy       = r_primed || r_state == DRAIN;
    assign io.frame_done = w_run_adv && r_fcnt == FW'(N-1);
    assign io.push       = w_run_adv;
    assign io.bf_en      = w_bf;
    assign io.sel_in     = w_bf;
    assign io.sel_out    = w_bf;
    assign io.pop        = r_state == DRAIN || (w_run_adv && (w_phase || r_primed));
    assign io.out_valid  = io.pop;
    assign io.tw_addr    = (w_adv && !w_phase) ? w_tw : '0;
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb_sdf_stage_ctrl: directed checks of two SDF stage sequencers (N=8 with DELAY=4 and DELAY=2).
module tb_sdf_stage_ctrl;
    logic clk, rst;
    int   n_chk = 0, n_fail = 0;
    int   e_cnt = 0, e_fcnt = 0;
    bit   e_pr = 0;

    sdf_stage_ctrl_if #(.TW_AW(2)) ia ();
    sdf_stage_ctrl_if #(.TW_AW(2)) ib ();

    sdf_stage_ctrl #(.N(8), .DELAY(4), .TW_AW(2)) u_a (.clk(clk), .rst(rst), .io(ia.slave));
    sdf_stage_ctrl #(.N(8), .DELAY(2), .TW_AW(2)) u_b (.clk(clk), .rst(rst), .io(ib.slave));

    logic [8:0] w_a, w_b;
    assign w_a = {ia.in_ready, ia.busy, ia.frame_done, ia.out_valid, ia.bf_en, ia.pop, ia.push, ia.sel_out, ia.sel_in};
    assign w_b = {ib.in_ready, ib.busy, ib.frame_done, ib.out_valid, ib.bf_en, ib.pop, ib.push, ib.sel_out, ib.sel_in};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] run_vec(bit ph, bit pr, bit fd, bit bz);
        return ph ? {1'b1, bz, fd, 6'b111111} : {1'b1, bz, fd, pr, 1'b0, pr, 1'b1, 1'b0, 1'b0};
    endfunction

    function automatic logic [1:0] exp_tw(int v);
`ifdef SDF_TW_BITREV_EN
        return {v[0], v[1]};
`else
        return 2'(v);
`endif
    endfunction

    task automatic a_run(int n, bit d);
        for (int k = 0; k < n; k++) begin
            bit ph;
            ia.in_valid = 1'b1;
            ia.drain    = d;
            #2;
            ph = e_cnt >= 4;
            check($sformatf("a_ctl c%0d f%0d", e_cnt, e_fcnt), w_a, run_vec(ph, e_pr, e_fcnt == 7, e_pr));
            check($sformatf("a_tw c%0d", e_cnt), ia.tw_addr, ph ? 0 : exp_tw(e_cnt % 4));
            if (e_cnt == 7) e_pr = 1'b1;
            e_cnt  = (e_cnt + 1) % 8;
            e_fcnt = (e_fcnt + 1) % 8;
            tick();
        end
        ia.in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ia.in_valid = 1'b0; ia.drain = 1'b0;
        ib.in_valid = 1'b0; ib.drain = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #2;
        check("rst_a", w_a, 9'b100000000);
        check("rst_a_tw", ia.tw_addr, 0);
        check("rst_b", w_b, 9'b100000000);
        tick();
        // back-to-back frames on the DELAY=2 stage
        for (int k = 0; k < 16; k++) begin
            bit ph, pr;
            ib.in_valid = 1'b1;
            #2;
            ph = (k % 4) >= 2;
            pr = k >= 4;
            check($sformatf("b_ctl k%0d", k), w_b, run_vec(ph, pr, k == 7 || k == 15, pr));
            check($sformatf("b_tw k%0d", k), ib.tw_addr, ph ? 0 : exp_tw(2 * (k % 2)));
            tick();
        end
        ib.in_valid = 1'b0;
        a_run(8, 1'b0);
        ia.drain = 1'b1;
        #2;
        check("a_pre_drain", w_a, 9'b110000000);
        tick();
        for (int k = 0; k < 4; k++) begin
            #2;
            check($sformatf("a_drain k%0d", k), w_a, 9'b010101000);
            check($sformatf("a_drain_tw k%0d", k), ia.tw_addr, exp_tw(k));
            tick();
        end
        #2;
        check("a_post_drain", w_a, 9'b100000000);
        tick();
        e_cnt = 0;
        e_pr  = 1'b0;
        ia.drain = 1'b0;
        a_run(5, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("a_stall k%0d", k), w_a, 9'b100000000);
            tick();
        end
        a_run(3, 1'b0);
        a_run(2, 1'b0);
        ia.drain = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2;
            check($sformatf("a_drain_ign k%0d", k), w_a, 9'b110000000);
            tick();
        end
        a_run(6, 1'b1);
        a_run(1, 1'b1);
        ia.drain = 1'b0;
        #2;
        check("a_valid_wins", w_a, 9'b110000000);
        tick();
        a_run(7, 1'b0);
        ia.drain = 1'b1;
        #2;
        check("a_pre_drain2", w_a, 9'b110000000);
        tick();
        #2;
        check("a_in_drain", w_a, 9'b010101000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ia.drain = 1'b0;
        #2;
        check("a_rst_drain", w_a, 9'b100000000);
        check("a_rst_drain_tw", ia.tw_addr, 0);
        tick();
        e_cnt  = 0;
        e_fcnt = 0;
        e_pr   = 1'b0;
        a_run(8, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
